// File: rtl/matrix_accelerator_pkg.sv
// rtl/matrix_accelerator_pkg.sv - shared lane-count constants, routing types and slice-select helper
package matrix_accelerator_pkg;

  localparam int KERNELSIZE      = 3;
  localparam int inputPortCount  = KERNELSIZE;
  localparam int outputPortCount = KERNELSIZE;
  localparam int addressLength   = 2;

  typedef logic [addressLength-1:0] slice_idx_t;

  typedef enum logic {
    ROUTE_BROADCAST = 1'b0,
    ROUTE_DIRECT    = 1'b1
  } route_mode_e;

  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_BUSY = 1'b1
  } lane_state_e;

  // Broadcast indices past the last slice fall back to slice 0.
  function automatic slice_idx_t route_slice(input logic direct, input slice_idx_t addr,
                                             input slice_idx_t lane);
    if (route_mode_e'(direct) == ROUTE_DIRECT) return lane;
    if (addr >= slice_idx_t'(inputPortCount)) return '0;
    return addr;
  endfunction

endpackage

// File: rtl/matrix_accelerator_mac_lane.sv
// rtl/matrix_accelerator_mac_lane.sv - one lane: iterative shift-add multiplier, product register, accumulator
module mac_lane
  import matrix_accelerator_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    add,
  input  logic [DATA_WIDTH-1:0]   multiplier,
  input  logic [DATA_WIDTH-1:0]   multiplicand,
  output logic                    ready,
  output logic [2*DATA_WIDTH-1:0] accumulator
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  lane_state_e       state;
  logic [DATA_WIDTH-1:0] mplier;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     partial;
  logic [PW-1:0]     product;
  logic [CNT_W-1:0]  cnt;

  // DATA_WIDTH partial-product steps, then one edge to publish: DATA_WIDTH+1 edges total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LANE_IDLE;
      mplier      <= '0;
      mcand       <= '0;
      partial     <= '0;
      product     <= '0;
      cnt         <= '0;
      ready       <= 1'b0;
      accumulator <= '0;
    end else begin
      ready <= 1'b0;
      if (add) accumulator <= accumulator + product;
      case (state)
        LANE_IDLE: begin
          if (start) begin
            state   <= LANE_BUSY;
            mplier  <= multiplier;
            mcand   <= {{DATA_WIDTH{1'b0}}, multiplicand};
            partial <= '0;
            cnt     <= '0;
          end
        end
        LANE_BUSY: begin
          if (cnt == CNT_W'(DATA_WIDTH)) begin
            product <= partial;
            ready   <= 1'b1;
            state   <= LANE_IDLE;
          end else begin
            if (mplier[0]) partial <= partial + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= LANE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/matrix_accelerator.sv
// rtl/matrix_accelerator.sv - three-lane multiply/accumulate array with operand routing and final reduction
module matrix_accelerator
  import matrix_accelerator_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic [inputPortCount*DATA_WIDTH-1:0] multiplier_input,
  input  logic [inputPortCount*DATA_WIDTH-1:0] multiplicand_input,
  input  logic [addressLength-1:0]            AddressSelect,
  input  logic [inputPortCount-1:0]           mStart,
  output logic [KERNELSIZE-1:0]               mReady,
  input  logic                                direct,
  input  logic [outputPortCount-1:0]          Add,
  input  logic                                finalAdd,
  output logic [2*DATA_WIDTH-1:0]             finalAccumulate,
  output logic                                finalReady
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mplier_slice [inputPortCount];
  logic [PW-1:0]         lane_acc     [KERNELSIZE];
  logic [PW-1:0]         acc_sum;

  for (genvar s = 0; s < inputPortCount; s++) begin : g_slice
    assign mplier_slice[s] = multiplier_input[s*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar i = 0; i < KERNELSIZE; i++) begin : g_lane
    slice_idx_t sel;
    assign sel = route_slice(direct, AddressSelect, slice_idx_t'(i));

    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk          (Clk),
      .rst          (Rst),
      .start        (mStart[i]),
      .add          (Add[i]),
      .multiplier   (mplier_slice[sel]),
      .multiplicand (multiplicand_input[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready        (mReady[i]),
      .accumulator  (lane_acc[i])
    );
  end

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < KERNELSIZE; i++) acc_sum = acc_sum + lane_acc[i];
  end

  // Sum is taken from registered accumulators, so a same-edge Add is not yet included.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      finalAccumulate <= '0;
      finalReady      <= 1'b0;
    end else if (finalAdd) begin
      finalAccumulate <= acc_sum;
      finalReady      <= 1'b1;
    end else begin
      finalReady      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_accelerator.sv
// tb/tb_matrix_accelerator.sv - directed self-checking bench for matrix_accelerator
module tb_matrix_accelerator;

  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [3*DW-1:0] multiplier_input = '0;
  logic [3*DW-1:0] multiplicand_input = '0;
  logic [1:0]    AddressSelect = '0;
  logic [2:0]    mStart = '0;
  logic [2:0]    mReady;
  logic          direct = 1'b1;
  logic [2:0]    Add = '0;
  logic          finalAdd = 1'b0;
  logic [2*DW-1:0] finalAccumulate;
  logic          finalReady;

  int checks = 0;
  int errors = 0;

  matrix_accelerator #(.DATA_WIDTH(DW)) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .multiplier_input   (multiplier_input),
    .multiplicand_input (multiplicand_input),
    .AddressSelect      (AddressSelect),
    .mStart             (mStart),
    .mReady             (mReady),
    .direct             (direct),
    .Add                (Add),
    .finalAdd           (finalAdd),
    .finalAccumulate    (finalAccumulate),
    .finalReady         (finalReady)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge Clk);
    Rst = 1'b1; mStart = '0; Add = '0; finalAdd = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic load(input logic d, input logic [1:0] as,
                      input logic [DW-1:0] m0, m1, m2, c0, c1, c2);
    direct = d;
    AddressSelect = as;
    multiplier_input = {m2, m1, m0};
    multiplicand_input = {c2, c1, c0};
  endtask

  task automatic start_and_wait(input logic [2:0] mask, output int lat, output logic [2:0] seen);
    @(negedge Clk); mStart = mask;
    @(negedge Clk); mStart = '0;
    lat = -1; seen = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (mReady != 0) begin
        lat = c; seen = mReady;
        break;
      end
    end
  endtask

  task automatic pulse_add(input logic [2:0] mask);
    @(negedge Clk); Add = mask;
    @(negedge Clk); Add = '0;
  endtask

  task automatic reduce(output logic [2*DW-1:0] val, output logic rdy);
    @(negedge Clk); finalAdd = 1'b1;
    @(negedge Clk); val = finalAccumulate; rdy = finalReady; finalAdd = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset;
    logic [2*DW-1:0] v; logic r;
    @(negedge Clk);
    checks++; if (mReady !== 3'b000) begin errors++; $display("FAIL reset_mready: got %b expected 000", mReady); end
    checks++; if (finalReady !== 1'b0) begin errors++; $display("FAIL reset_final_ready: got %b expected 0", finalReady); end
    checks++; if (finalAccumulate !== '0) begin errors++; $display("FAIL reset_final_acc: got %h expected 0", finalAccumulate); end
    Rst = 1'b0;
    reduce(v, r);
    checks++; if (r !== 1'b1 || v !== 64'd0) begin errors++; $display("FAIL reset_reduce: got %0d/%b expected 0/1", v, r); end
  endtask

  task automatic test_direct;
    int lat; logic [2:0] seen; logic [2*DW-1:0] v; logic r;
    load(1'b1, 2'd0, 32'd3, 32'd7, 32'd0, 32'd5, 32'd11, 32'd9);
    start_and_wait(3'b111, lat, seen);
    checks++; if (lat !== 33) begin errors++; $display("FAIL direct_latency: got %0d expected 33", lat); end
    checks++; if (seen !== 3'b111) begin errors++; $display("FAIL direct_ready: got %b expected 111", seen); end
    @(negedge Clk);
    checks++; if (mReady !== 3'b000) begin errors++; $display("FAIL direct_pulse_width: got %b expected 000", mReady); end
    pulse_add(3'b001); reduce(v, r);
    checks++; if (v !== 64'd15 || r !== 1'b1) begin errors++; $display("FAIL direct_lane0: got %0d/%b expected 15/1", v, r); end
    pulse_add(3'b010); reduce(v, r);
    checks++; if (v !== 64'd92) begin errors++; $display("FAIL direct_lane1: got %0d expected 92", v); end
    pulse_add(3'b100); reduce(v, r);
    checks++; if (v !== 64'd92) begin errors++; $display("FAIL direct_lane2: got %0d expected 92", v); end
  endtask

  task automatic test_accumulate_hold;
    int lat; logic [2:0] seen;
    do_reset;
    load(1'b1, 2'd0, 32'd3, 32'd7, 32'd0, 32'd5, 32'd11, 32'd9);
    start_and_wait(3'b111, lat, seen);
    pulse_add(3'b111);
    @(negedge Clk); finalAdd = 1'b1;
    @(negedge Clk);
    checks++; if (finalReady !== 1'b1 || finalAccumulate !== 64'd92) begin errors++; $display("FAIL hold_first: got %0d/%b expected 92/1", finalAccumulate, finalReady); end
    Add = 3'b001;
    @(negedge Clk); Add = '0;
    checks++; if (finalReady !== 1'b1 || finalAccumulate !== 64'd92) begin errors++; $display("FAIL hold_pre_add: got %0d/%b expected 92/1", finalAccumulate, finalReady); end
    @(negedge Clk);
    checks++; if (finalReady !== 1'b1 || finalAccumulate !== 64'd107) begin errors++; $display("FAIL hold_recompute: got %0d/%b expected 107/1", finalAccumulate, finalReady); end
    finalAdd = 1'b0;
    @(negedge Clk);
    checks++; if (finalReady !== 1'b0 || finalAccumulate !== 64'd107) begin errors++; $display("FAIL hold_drop: got %0d/%b expected 107/0", finalAccumulate, finalReady); end
    repeat (3) @(negedge Clk);
    checks++; if (finalAccumulate !== 64'd107) begin errors++; $display("FAIL hold_keep: got %0d expected 107", finalAccumulate); end
  endtask

  task automatic test_wrap;
    int lat; logic [2:0] seen; logic [2*DW-1:0] v; logic r;
    do_reset;
    load(1'b1, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    start_and_wait(3'b001, lat, seen);
    checks++; if (lat !== 33 || seen !== 3'b001) begin errors++; $display("FAIL wrap_ready: got %0d/%b expected 33/001", lat, seen); end
    pulse_add(3'b001); reduce(v, r);
    checks++; if (v !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL wrap_product: got %h expected fffffffe00000001", v); end
    pulse_add(3'b001); reduce(v, r);
    checks++; if (v !== 64'hFFFF_FFFC_0000_0002) begin errors++; $display("FAIL wrap_acc: got %h expected fffffffc00000002", v); end
  endtask

  task automatic test_broadcast;
    int lat; logic [2:0] seen; logic [2*DW-1:0] v; logic r;
    do_reset;
    load(1'b0, 2'd2, 32'd1, 32'd2, 32'd4, 32'd10, 32'd20, 32'd30);
    start_and_wait(3'b111, lat, seen);
    checks++; if (seen !== 3'b111) begin errors++; $display("FAIL bcast_ready: got %b expected 111", seen); end
    pulse_add(3'b001); reduce(v, r);
    checks++; if (v !== 64'd40) begin errors++; $display("FAIL bcast_lane0: got %0d expected 40", v); end
    @(negedge Clk); Add = 3'b010; finalAdd = 1'b1;
    @(negedge Clk); Add = '0;
    checks++; if (finalAccumulate !== 64'd40) begin errors++; $display("FAIL same_edge_add: got %0d expected 40", finalAccumulate); end
    @(negedge Clk); finalAdd = 1'b0;
    checks++; if (finalAccumulate !== 64'd120) begin errors++; $display("FAIL bcast_lane1: got %0d expected 120", finalAccumulate); end
    pulse_add(3'b100); reduce(v, r);
    checks++; if (v !== 64'd240) begin errors++; $display("FAIL bcast_lane2: got %0d expected 240", v); end
    do_reset;
    load(1'b0, 2'd3, 32'd1, 32'd2, 32'd4, 32'd10, 32'd20, 32'd30);
    start_and_wait(3'b111, lat, seen);
    pulse_add(3'b001); reduce(v, r);
    checks++; if (v !== 64'd10) begin errors++; $display("FAIL bcast3_lane0: got %0d expected 10", v); end
    pulse_add(3'b010); reduce(v, r);
    checks++; if (v !== 64'd30) begin errors++; $display("FAIL bcast3_lane1: got %0d expected 30", v); end
    pulse_add(3'b100); reduce(v, r);
    checks++; if (v !== 64'd60) begin errors++; $display("FAIL bcast3_lane2: got %0d expected 60", v); end
  endtask

  task automatic test_back_to_back;
    int first; int second;
    do_reset;
    load(1'b1, 2'd0, 32'd3, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0);
    first = -1; second = -1;
    @(negedge Clk); mStart = 3'b001;
    for (int c = 0; c <= 80; c++) begin
      @(negedge Clk);
      if (mReady[0]) begin
        if (first < 0) first = c;
        else begin second = c; mStart = '0; break; end
      end
    end
    mStart = '0;
    checks++; if (first !== 33) begin errors++; $display("FAIL b2b_first: got %0d expected 33", first); end
    checks++; if (second !== 67) begin errors++; $display("FAIL b2b_second: got %0d expected 67", second); end
  endtask

  task automatic test_busy_ignore;
    int pulses; int lat; logic [2*DW-1:0] v; logic r;
    do_reset;
    load(1'b1, 2'd0, 32'd3, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0);
    pulses = 0; lat = -1;
    @(negedge Clk); mStart = 3'b001;
    @(negedge Clk); mStart = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge Clk);
      if (c == 5) begin mStart = 3'b001; load(1'b1, 2'd0, 32'd6, 32'd0, 32'd0, 32'd7, 32'd0, 32'd0); end
      if (c == 20) mStart = '0;
      if (mReady[0]) begin pulses++; if (pulses == 1) lat = c; end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_latency: got %0d expected 33", lat); end
    pulse_add(3'b001); reduce(v, r);
    checks++; if (v !== 64'd15) begin errors++; $display("FAIL busy_product: got %0d expected 15", v); end
  endtask

  task automatic test_reset_abort;
    int lat; int pulses; logic [2:0] seen; logic [2*DW-1:0] v; logic r;
    do_reset;
    load(1'b1, 2'd0, 32'd3, 32'd7, 32'd0, 32'd5, 32'd11, 32'd9);
    start_and_wait(3'b111, lat, seen);
    pulse_add(3'b011);
    @(negedge Clk); finalAdd = 1'b1; mStart = 3'b111;
    @(negedge Clk); mStart = '0;
    checks++; if (finalAccumulate !== 64'd92 || finalReady !== 1'b1) begin errors++; $display("FAIL abort_pre: got %0d/%b expected 92/1", finalAccumulate, finalReady); end
    repeat (10) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    checks++; if (finalReady !== 1'b0 || finalAccumulate !== '0 || mReady !== 3'b000) begin errors++; $display("FAIL abort_async: got %0d/%b/%b expected 0/0/000", finalAccumulate, finalReady, mReady); end
    mStart = 3'b111; Add = 3'b111;
    @(negedge Clk);
    checks++; if (finalReady !== 1'b0 || finalAccumulate !== '0) begin errors++; $display("FAIL abort_held: got %0d/%b expected 0/0", finalAccumulate, finalReady); end
    Rst = 1'b0; mStart = '0; Add = '0; finalAdd = 1'b0;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge Clk);
      if (mReady != 0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d expected 0", pulses); end
    pulse_add(3'b111); reduce(v, r);
    checks++; if (v !== 64'd0 || r !== 1'b1) begin errors++; $display("FAIL abort_cleared: got %0d/%b expected 0/1", v, r); end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_accumulate_hold;
    test_wrap;
    test_broadcast;
    test_back_to_back;
    test_busy_ignore;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
